fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage: owns the program counter, selects the next fetch address, and drives the synchronous i_cache address port. Its outputs feed the fetch/decode pipeline register. It absorbs branch redirects from decode (predicted taken) and execute (mispredict), including redirects that arrive while fetch is stalled. It also keeps fetch and stall performance counters.

## Interface
- ADDR_WIDTH, 32, width of PC and cache address
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_WIDTH, 32, width of each performance counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_hc_stall  in  1  stall request from hazard control for the fetch stage
- i_dec_redirect  in  1  decode predicts taken; target on i_dec_target
- i_dec_target  in  ADDR_WIDTH  predicted branch target
- i_ex_redirect  in  1  execute detected a mispredict; target on i_ex_target
- i_ex_target  in  ADDR_WIDTH  corrected PC
- i_cache_hit  in  1  i_cache data valid for the current o_pc
- i_cache_data  in  32  instruction word from i_cache
- o_cache_addr_next  out  ADDR_WIDTH  address for the synchronous cache to read next cycle
- o_pc  out  ADDR_WIDTH  PC of the instruction currently presented
- o_inst_valid  out  1  o_inst_data is a real, non-squashed instruction
- o_inst_data  out  32  instruction word (i_cache_data passthrough)
- o_fetch_stall  out  1  fetch is holding this cycle
- o_fetch_count  out  CNT_WIDTH  instructions accepted
- o_stall_count  out  CNT_WIDTH  stalled cycles

## Operation
- State: pc register, pending_valid, pending_target, two counters.
- o_fetch_stall = i_hc_stall | ~i_cache_hit.
- Redirect target for this cycle: i_ex_target if i_ex_redirect, else i_dec_target if i_dec_redirect. EX always has priority over DEC.
- Next-PC priority when not stalled:
  - 1. i_ex_redirect
  - 2. pending_valid (pending_target)
  - 3. i_dec_redirect
  - 4. pc + 4, which wraps modulo 2^ADDR_WIDTH.
- All targets have bits [1:0] forced to 0.
- Stalled cycle:
  - pc holds.
  - If any redirect is present, pending_valid <= 1 and pending_target <= that cycle's redirect target.
  - An EX redirect overwrites any pending entry. A DEC redirect overwrites only when pending_valid=0 or the entry came from DEC, so a pending_src bit is needed.
- Non-stalled cycle: pc <= next PC; pending_valid <= 0.
- o_cache_addr_next = pc when stalled, else next PC (combinational). This way the synchronous cache presents data for o_pc each cycle.
- o_pc = pc.
- o_inst_valid = i_cache_hit & ~i_ex_redirect & ~i_dec_redirect & ~pending_valid.
- o_inst_data = i_cache_data.
- Counters saturate at all-ones:
  - o_fetch_count += 1 when o_inst_valid & ~o_fetch_stall.
  - o_stall_count += 1 when o_fetch_stall.

## Timing
- Reset (async assert, sync-release use):
  - pc = RESET_PC, pending_valid = 0, pending_src = 0, pending_target = 0, both counters 0.
  - With i_cache_hit=0: o_pc = RESET_PC, o_cache_addr_next = RESET_PC, o_inst_valid = 0.
- Redirect latency: a redirect accepted in cycle N (not stalled) sets o_pc = target in cycle N+1.
- A redirect during a stall takes effect on the first non-stalled cycle's edge.
- Squash: an instruction presented in the same cycle as a redirect, or while pending_valid=1, is never valid.
- Simultaneous EX and DEC redirect: EX wins, and the DEC redirect is dropped.
- Simultaneous EX redirect and pending entry: EX wins, and pending is cleared on that edge.
- Reset mid-stall discards any pending redirect.
- Counter at max stays at max. No wrap.

## Test plan
- Reset, then hit every cycle with no redirects → o_pc sequence 0, 4, 8, 12; o_fetch_count=4 after 4 accepted cycles; o_inst_valid=1 throughout.
- EX redirect to 0x100 at PC 0x8, not stalled → next o_pc=0x100; the instruction at 0x8 has o_inst_valid=0; o_cache_addr_next=0x100 in the redirect cycle.
- Stall for 3 cycles with i_cache_hit=0, DEC redirect 0x40 in stall cycle 1 → o_pc held, o_cache_addr_next=o_pc, o_inst_valid=0; after release o_pc=0x40; o_stall_count=3.
- During a stall, DEC 0x40 then EX 0x80 in a later cycle, then DEC 0x20 → after release o_pc=0x80 (EX not overwritten by DEC).
- Same cycle EX 0x200 and DEC 0x300, target 0x203 misaligned → o_pc=0x200.
- pc=0xFFFF_FFFC unstalled → o_pc=0x0; preload o_stall_count near max, stall → count holds at 0xFFFF_FFFF; assert rst_n mid-stall with pending set → o_pc=RESET_PC, no pending redirect applied after reset.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-address select, redirect
// buffering across stalls, and saturating fetch/stall counters.
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_hc_stall,
  input  logic                  i_dec_redirect,
  input  logic [ADDR_WIDTH-1:0] i_dec_target,
  input  logic                  i_ex_redirect,
  input  logic [ADDR_WIDTH-1:0] i_ex_target,
  input  logic                  i_cache_hit,
  input  logic [31:0]           i_cache_data,
  output logic [ADDR_WIDTH-1:0] o_cache_addr_next,
  output logic [ADDR_WIDTH-1:0] o_pc,
  output logic                  o_inst_valid,
  output logic [31:0]           o_inst_data,
  output logic                  o_fetch_stall,
  output logic [CNT_WIDTH-1:0]  o_fetch_count,
  output logic [CNT_WIDTH-1:0]  o_stall_count
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE = CNT_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] pc;
  logic                  pending_valid;
  logic                  pending_src;
  logic [ADDR_WIDTH-1:0] pending_target;
  logic [CNT_WIDTH-1:0]  fetch_cnt;
  logic [CNT_WIDTH-1:0]  stall_cnt;

  logic                  stall;
  logic                  any_redirect;
  logic [ADDR_WIDTH-1:0] ex_tgt;
  logic [ADDR_WIDTH-1:0] dec_tgt;
  logic [ADDR_WIDTH-1:0] redir_tgt;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic                  take_pend;
  logic                  fetch_inc;

  assign stall        = i_hc_stall | ~i_cache_hit;
  assign any_redirect = i_ex_redirect | i_dec_redirect;
  assign ex_tgt       = {i_ex_target[ADDR_WIDTH-1:2], 2'b00};
  assign dec_tgt      = {i_dec_target[ADDR_WIDTH-1:2], 2'b00};
  assign redir_tgt    = i_ex_redirect ? ex_tgt : dec_tgt;

  // pending_src=1 marks an EX entry, which a later DEC must not displace
  assign take_pend = i_ex_redirect
                   | (i_dec_redirect & (~pending_valid | ~pending_src));

  always_comb begin
    next_pc = pc + PC_STEP;
    if (i_ex_redirect)
      next_pc = ex_tgt;
    else if (pending_valid)
      next_pc = pending_target;
    else if (i_dec_redirect)
      next_pc = dec_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= RESET_PC;
      pending_valid  <= 1'b0;
      pending_src    <= 1'b0;
      pending_target <= '0;
    end else if (stall) begin
      if (any_redirect && take_pend) begin
        pending_valid  <= 1'b1;
        pending_src    <= i_ex_redirect;
        pending_target <= redir_tgt;
      end
    end else begin
      pc            <= next_pc;
      pending_valid <= 1'b0;
      pending_src   <= 1'b0;
    end
  end

  assign fetch_inc = o_inst_valid & ~stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_inc && !(&fetch_cnt))
        fetch_cnt <= fetch_cnt + CNT_ONE;
      if (stall && !(&stall_cnt))
        stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign o_fetch_stall     = stall;
  assign o_cache_addr_next = stall ? pc : next_pc;
  assign o_pc              = pc;
  assign o_inst_valid      = i_cache_hit & ~any_redirect & ~pending_valid;
  assign o_inst_data       = i_cache_data;
  assign o_fetch_count     = fetch_cnt;
  assign o_stall_count     = stall_cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk;
  logic        rst_n;
  logic        hc;
  logic        dr;
  logic [31:0] dt;
  logic        er;
  logic [31:0] et;
  logic        hit;
  logic [31:0] data;
  logic [31:0] addr_next;
  logic [31:0] pc;
  logic        ivalid;
  logic [31:0] idata;
  logic        fstall;
  logic [CW-1:0] fcnt;
  logic [CW-1:0] scnt;

  int n_checks;
  int n_errors;

  logic [31:0] m_pc;
  logic        m_pv;
  logic        m_ps;
  logic [31:0] m_pt;
  int          m_fc;
  int          m_sc;

  fetch_unit #(
    .ADDR_WIDTH(32),
    .RESET_PC(32'h0),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_hc_stall(hc),
    .i_dec_redirect(dr),
    .i_dec_target(dt),
    .i_ex_redirect(er),
    .i_ex_target(et),
    .i_cache_hit(hit),
    .i_cache_data(data),
    .o_cache_addr_next(addr_next),
    .o_pc(pc),
    .o_inst_valid(ivalid),
    .o_inst_data(idata),
    .o_fetch_stall(fstall),
    .o_fetch_count(fcnt),
    .o_stall_count(scnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] exp_next();
    if (er) return al(et);
    if (m_pv) return m_pt;
    if (dr) return al(dt);
    return m_pc + 32'd4;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    m_pv = 1'b0;
    m_ps = 1'b0;
    m_pt = 32'h0;
    m_fc = 0;
    m_sc = 0;
  endtask

  // one clock: drive at negedge, compare combinational view, advance model
  task automatic cyc(input logic s_hc, input logic s_dr, input logic [31:0] s_dt,
                     input logic s_er, input logic [31:0] s_et,
                     input logic s_hit, input logic [31:0] s_data);
    logic st;
    logic v;
    logic [31:0] nx;
    hc = s_hc; dr = s_dr; dt = s_dt;
    er = s_er; et = s_et; hit = s_hit; data = s_data;
    #2;
    st = s_hc || !s_hit;
    v  = s_hit && !s_er && !s_dr && !m_pv;
    nx = exp_next();
    chk("pc", pc, m_pc);
    chk("stall", fstall, st);
    chk("valid", ivalid, v);
    chk("addr_next", addr_next, st ? m_pc : nx);
    chk("data", idata, s_data);
    chk("fcnt", fcnt, m_fc);
    chk("scnt", scnt, m_sc);
    @(posedge clk);
    if (st) begin
      if (s_er) begin
        m_pv = 1'b1; m_ps = 1'b1; m_pt = al(s_et);
      end else if (s_dr && (!m_pv || !m_ps)) begin
        m_pv = 1'b1; m_ps = 1'b0; m_pt = al(s_dt);
      end
      if (m_sc < CMAX) m_sc++;
    end else begin
      m_pc = nx;
      m_pv = 1'b0;
      m_ps = 1'b0;
      if (v && m_fc < CMAX) m_fc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    hc = 1'b0; dr = 1'b0; er = 1'b0; hit = 1'b0;
    dt = '0; et = '0; data = '0;
    #2;
    model_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_addr", addr_next, 32'h0);
    chk("rst_valid", ivalid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input logic s_hit);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, s_hit, $urandom);
  endtask

  initial begin
    int s0;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 4; i++) begin
      chk("seq_pc", pc, 32'(i * 4));
      run(1'b1);
    end
    chk("fcnt4", fcnt, 4);

    do_reset();
    run(1'b1);
    run(1'b1);
    chk("at8", pc, 32'h8);
    hc = 0; er = 1; et = 32'h100; dr = 0; hit = 1;
    #1;
    chk("ex_valid", ivalid, 1'b0);
    chk("ex_addr", addr_next, 32'h100);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 32'h1234);
    chk("ex_pc", pc, 32'h100);

    s0 = m_sc;
    cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    cyc(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("stall_hold", pc, 32'h100);
    chk("stall_cnt3", scnt, 32'(s0 + 3));
    run(1'b1);
    chk("pend_dec", pc, 32'h40);

    cyc(1'b1, 1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h0);
    cyc(1'b1, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 32'h0);
    cyc(1'b1, 1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 32'h0);
    run(1'b1);
    chk("pend_ex_kept", pc, 32'h80);

    cyc(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h0);
    chk("ex_over_dec", pc, 32'h200);
    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'h203, 1'b1, 32'h0);
    chk("misalign", pc, 32'h200);

    cyc(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b1, 32'h0);
    run(1'b1);
    chk("wrap", pc, 32'h0);

    for (int i = 0; i < CMAX + 10; i++) run(1'b0);
    chk("sat_stall", scnt, CMAX);

    cyc(1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    hc = 1; hit = 0; dr = 0; er = 0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_cnt", scnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b1);
    chk("no_pend", pc, 32'h4);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] t1;
      logic [31:0] t2;
      t1 = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      t2 = $urandom;
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, t1,
          $urandom_range(0, 7) == 0, t2, $urandom_range(0, 3) != 0,
          $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
